// File: rtl/char_motion.sv
// Tick-paced player mover: horizontal walk, jump/fall state machine, map-flag collision.
// Optional air jump is built when CHAR_AIR_JUMP_EN is defined.
module char_motion #(
   parameter int unsigned CLK_DIV = 99999,
   parameter int unsigned XW      = 10,
   parameter int unsigned YW      = 10,
   parameter int unsigned X_INIT  = 16,
   parameter int unsigned Y_INIT  = 300,
   parameter int unsigned X_MAX   = 960,
   parameter int unsigned Y_FLOOR = 400,
   parameter int unsigned JUMP_H  = 48
) (
   input  logic          sys_clk,
   input  logic          rst_n,
   input  logic [3:0]    mov,
   input  logic          solid_l,
   input  logic          solid_r,
   input  logic          solid_up,
   input  logic          solid_dn,
   output logic [XW-1:0] char_X,
   output logic [YW-1:0] char_Y,
   output logic [1:0]    state,
   output logic          on_ground,
   output logic          tick
);

   localparam int unsigned DW = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
   localparam int unsigned JW = (JUMP_H > 0) ? $clog2(JUMP_H + 1) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV);
   localparam logic [XW-1:0] X_RST    = XW'(X_INIT);
   localparam logic [XW-1:0] X_LAST   = XW'(X_MAX);
   localparam logic [YW-1:0] Y_RST    = YW'(Y_INIT);
   localparam logic [YW-1:0] Y_LAST   = YW'(Y_FLOOR);
   localparam logic [JW-1:0] J_LAST   = JW'(JUMP_H);
   localparam logic [JW-1:0] J_ONE    = JW'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FALLING = 2'd1,
      ST_JUMPING = 2'd2
   } motion_e;

   logic [DW-1:0] div_q, div_d;
   logic          tick_q, tick_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   motion_e       st_q, st_d;
   logic [JW-1:0] jcnt_q, jcnt_d;
   logic          on_ground_q, on_ground_d;

   logic go_left, go_right, up_ok, fall_ok, air_fire;

   // The down key is reserved; keep it visibly consumed.
   logic unused_mov_dn;
   assign unused_mov_dn = mov[2];

   // tick_q mirrors "divider at its last count", so it doubles as the step enable.
   always_comb begin
      div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      tick_d = (div_d == DIV_LAST);
   end

   assign go_left  = mov[1] & ~mov[0] & (x_q != '0) & ~solid_l;
   assign go_right = mov[0] & ~mov[1] & (x_q < X_LAST) & ~solid_r;
   assign up_ok    = ~solid_up & (y_q != '0);
   assign fall_ok  = ~solid_dn & (y_q < Y_LAST);

`ifdef CHAR_AIR_JUMP_EN
   logic air_q, air_d;
   logic up_prev_q, up_prev_d;

   assign air_fire = tick_q & (st_q != ST_IDLE) & mov[3] & ~up_prev_q & air_q & up_ok;
`else
   assign air_fire = 1'b0;
`endif

   always_comb begin
      // NOTE: every target gets a hold value first so no path can infer a latch.
      x_d    = x_q;
      y_d    = y_q;
      st_d   = st_q;
      jcnt_d = jcnt_q;
`ifdef CHAR_AIR_JUMP_EN
      air_d     = air_q;
      up_prev_d = up_prev_q;
`endif
      if (tick_q) begin
         if (go_left) begin
            x_d = x_q - 1'b1;
         end else if (go_right) begin
            x_d = x_q + 1'b1;
         end
`ifdef CHAR_AIR_JUMP_EN
         up_prev_d = mov[3];
`endif
         if (air_fire) begin
            st_d   = ST_JUMPING;
            y_d    = y_q - 1'b1;
            jcnt_d = J_ONE;
`ifdef CHAR_AIR_JUMP_EN
            air_d  = 1'b0;
`endif
         end else begin
            unique case (st_q)
               ST_IDLE: begin
                  if (mov[3] & up_ok) begin
                     st_d   = ST_JUMPING;
                     y_d    = y_q - 1'b1;
                     jcnt_d = J_ONE;
                  end else if (fall_ok) begin
                     st_d = ST_FALLING;
                     y_d  = y_q + 1'b1;
                  end
               end
               ST_JUMPING: begin
                  // Peak reached or jump cut short: hang for one tick, then fall.
                  if (~mov[3] | ~up_ok | (jcnt_q == J_LAST)) begin
                     st_d = ST_FALLING;
                  end else begin
                     y_d    = y_q - 1'b1;
                     jcnt_d = jcnt_q + 1'b1;
                  end
               end
               ST_FALLING: begin
                  if (solid_dn | (y_q >= Y_LAST)) begin
                     st_d   = ST_IDLE;
                     jcnt_d = '0;
`ifdef CHAR_AIR_JUMP_EN
                     air_d  = 1'b1;
`endif
                  end else begin
                     y_d = y_q + 1'b1;
                  end
               end
               default: st_d = ST_FALLING;
            endcase
         end
      end
      on_ground_d = (st_d == ST_IDLE);
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         div_q       <= '0;
         tick_q      <= 1'b0;
         x_q         <= X_RST;
         y_q         <= Y_RST;
         st_q        <= ST_IDLE;
         jcnt_q      <= '0;
         on_ground_q <= 1'b1;
`ifdef CHAR_AIR_JUMP_EN
         air_q       <= 1'b1;
         up_prev_q   <= 1'b0;
`endif
      end else begin
         div_q       <= div_d;
         tick_q      <= tick_d;
         x_q         <= x_d;
         y_q         <= y_d;
         st_q        <= st_d;
         jcnt_q      <= jcnt_d;
         on_ground_q <= on_ground_d;
`ifdef CHAR_AIR_JUMP_EN
         air_q       <= air_d;
         up_prev_q   <= up_prev_d;
`endif
      end
   end

   assign char_X    = x_q;
   assign char_Y    = y_q;
   assign state     = st_q;
   assign on_ground = on_ground_q;
   assign tick      = tick_q;

endmodule

// File: tb/tb_char_motion.sv
// Directed and random stimulus for char_motion, checked against a tick-level reference model.
module tb_char_motion;

   localparam int CLK_DIV = 3;
   localparam int X_INIT  = 16;
   localparam int Y_INIT  = 300;
   localparam int X_MAX   = 960;
   localparam int Y_FLOOR = 400;
   localparam int JUMP_H  = 48;

   localparam int S_IDLE = 0;
   localparam int S_FALL = 1;
   localparam int S_JUMP = 2;

   logic       sys_clk = 1'b0;
   logic       rst_n   = 1'b0;
   logic [3:0] mov     = 4'b0000;
   logic       solid_l = 1'b0, solid_r = 1'b0, solid_up = 1'b0, solid_dn = 1'b0;
   logic [9:0] char_X;
   logic [9:0] char_Y;
   logic [1:0] state;
   logic       on_ground;
   logic       tick;

   char_motion #(
      .CLK_DIV(CLK_DIV), .XW(10), .YW(10), .X_INIT(X_INIT), .Y_INIT(Y_INIT),
      .X_MAX(X_MAX), .Y_FLOOR(Y_FLOOR), .JUMP_H(JUMP_H)
   ) dut (
      .sys_clk(sys_clk), .rst_n(rst_n), .mov(mov),
      .solid_l(solid_l), .solid_r(solid_r), .solid_up(solid_up), .solid_dn(solid_dn),
      .char_X(char_X), .char_Y(char_Y), .state(state), .on_ground(on_ground), .tick(tick)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int n_assert = 0;
   int n_fail   = 0;
   int last_tick_cyc = 0;
   bit tick_seen = 1'b0;

   // Reference model: character position and motion as plain integers.
   int m_x, m_y, m_st, m_rise, m_air, m_prev_up;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_x = X_INIT; m_y = Y_INIT; m_st = S_IDLE; m_rise = 0; m_air = 1; m_prev_up = 0;
   endtask

   task automatic model_step(input logic [3:0] m, input logic l, input logic r,
                             input logic u, input logic d);
      bit air_taken = 1'b0;
      if (m[1] && !m[0] && m_x > 0 && !l) m_x = m_x - 1;
      else if (m[0] && !m[1] && m_x < X_MAX && !r) m_x = m_x + 1;
`ifdef CHAR_AIR_JUMP_EN
      if (m_st != S_IDLE && m[3] && m_prev_up == 0 && m_air == 1 && !u && m_y > 0) begin
         m_st = S_JUMP; m_y = m_y - 1; m_rise = 1; m_air = 0; air_taken = 1'b1;
      end
      m_prev_up = int'(m[3]);
`endif
      if (!air_taken) begin
         if (m_st == S_IDLE) begin
            if (m[3] && !u && m_y > 0) begin
               m_st = S_JUMP; m_y = m_y - 1; m_rise = 1;
            end else if (!d && m_y < Y_FLOOR) begin
               m_st = S_FALL; m_y = m_y + 1;
            end
         end else if (m_st == S_JUMP) begin
            if (!m[3] || u || m_y == 0 || m_rise == JUMP_H) m_st = S_FALL;
            else begin
               m_y = m_y - 1; m_rise = m_rise + 1;
            end
         end else begin
            if (d || m_y >= Y_FLOOR) begin
               m_st = S_IDLE; m_rise = 0; m_air = 1;
            end else m_y = m_y + 1;
         end
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_x"}, 32'(char_X), m_x);
      chk({tag, "_y"}, 32'(char_Y), m_y);
      chk({tag, "_state"}, 32'(state), m_st);
      chk({tag, "_on_ground"}, 32'(on_ground), (m_st == S_IDLE) ? 1 : 0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_x"}, 32'(char_X), X_INIT);
      chk({tag, "_y"}, 32'(char_Y), Y_INIT);
      chk({tag, "_state"}, 32'(state), S_IDLE);
      chk({tag, "_on_ground"}, 32'(on_ground), 1);
      chk({tag, "_tick"}, 32'(tick), 0);
   endtask

   task automatic reset_dut();
      rst_n = 1'b0; mov = 4'b0000;
      solid_l = 1'b0; solid_r = 1'b0; solid_up = 1'b0; solid_dn = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      check_reset_values("reset");
      rst_n = 1'b1;
      model_reset();
      tick_seen = 1'b0;
   endtask

   task automatic wait_tick(output bit ok);
      int n = 0;
      while (tick !== 1'b1 && n < 16) begin
         @(posedge sys_clk);
         #1;
         n++;
      end
      ok = (tick === 1'b1);
      if (!ok) chk("tick_timeout", 0, 1);
      else if (tick_seen) chk("tick_period", cyc - last_tick_cyc, CLK_DIV + 1);
      last_tick_cyc = cyc;
      tick_seen = 1'b1;
   endtask

   task automatic step(input logic [3:0] m, input logic l, input logic r,
                       input logic u, input logic d);
      bit ok;
      mov = m; solid_l = l; solid_r = r; solid_up = u; solid_dn = d;
      wait_tick(ok);
      if (ok) model_step(m, l, r, u, d);
      @(posedge sys_clk);
      #1;
      chk("tick_pulse", 32'(tick), 0);
      check_model("step");
   endtask

   initial begin
      bit ok;

      // Reset, first fall step.
      reset_dut();
      step(4'b0000, 0, 0, 0, 0);
      chk("first_fall_state", 32'(state), S_FALL);
      chk("first_fall_y", 32'(char_Y), 301);

      // Full-height jump, peak hang, fall, landing.
      reset_dut();
      for (int i = 0; i < JUMP_H; i++) step(4'b1000, 0, 0, 0, 1);
      chk("jump_peak_y", 32'(char_Y), 252);
      chk("jump_peak_state", 32'(state), S_JUMP);
      step(4'b1000, 0, 0, 0, 1);
      chk("peak_hold_y", 32'(char_Y), 252);
      chk("peak_hold_state", 32'(state), S_FALL);
      for (int i = 0; i < 5; i++) step(4'b0000, 0, 0, 0, 0);
      step(4'b0000, 0, 0, 0, 1);
      chk("landed_state", 32'(state), S_IDLE);
      chk("landed_y", 32'(char_Y), 257);

      // Short jump released after ten ticks.
      reset_dut();
      for (int i = 0; i < 10; i++) step(4'b1000, 0, 0, 0, 1);
      chk("short_jump_y", 32'(char_Y), 290);
      step(4'b0000, 0, 0, 0, 1);
      chk("short_release_state", 32'(state), S_FALL);
      chk("short_release_y", 32'(char_Y), 290);

      // Horizontal bounds, wall, both keys.
      reset_dut();
      for (int i = 0; i < X_INIT + 1; i++) step(4'b0010, 0, 0, 0, 1);
      chk("left_bound_x", 32'(char_X), 0);
      for (int i = 0; i < 100; i++) step(4'b0001, 0, 0, 0, 1);
      step(4'b0001, 0, 1, 0, 1);
      chk("wall_right_x", 32'(char_X), 100);
      step(4'b0011, 0, 0, 0, 1);
      chk("both_keys_x", 32'(char_X), 100);
      for (int i = 0; i < X_MAX - 100 + 1; i++) step(4'b0001, 0, 0, 0, 1);
      chk("right_bound_x", 32'(char_X), X_MAX);
      step(4'b1001, 0, 0, 0, 1);
      chk("diag_x", 32'(char_X), X_MAX);
      chk("diag_y", 32'(char_Y), Y_INIT - 1);

      // Reset asserted in a tick cycle, mid-jump.
      reset_dut();
      for (int i = 0; i < 30; i++) step(4'b1000, 0, 0, 0, 1);
      chk("mid_jump_y", 32'(char_Y), 270);
      wait_tick(ok);
      rst_n = 1'b0;
      @(posedge sys_clk);
      #1;
      check_reset_values("mid_jump_reset");
      rst_n = 1'b1;
      model_reset();
      tick_seen = 1'b0;
      for (int i = 0; i < JUMP_H + 1; i++) step(4'b1000, 0, 0, 0, 1);
      chk("post_reset_peak_y", 32'(char_Y), Y_INIT - JUMP_H);

      // Air jump while falling.
      reset_dut();
      for (int i = 0; i < 20; i++) step(4'b0000, 0, 0, 0, 0);
      chk("air_start_y", 32'(char_Y), 320);
      step(4'b1000, 0, 0, 0, 0);
`ifdef CHAR_AIR_JUMP_EN
      chk("air_press_state", 32'(state), S_JUMP);
      chk("air_press_y", 32'(char_Y), 319);
`else
      chk("air_press_state", 32'(state), S_FALL);
      chk("air_press_y", 32'(char_Y), 321);
`endif
      for (int i = 0; i < 3; i++) step(4'b1000, 0, 0, 0, 0);
      step(4'b0000, 0, 0, 0, 0);
      step(4'b1000, 0, 0, 0, 0);
      chk("second_press_state", 32'(state), S_FALL);
      step(4'b0000, 0, 0, 0, 1);
      chk("air_land_state", 32'(state), S_IDLE);
      step(4'b0000, 0, 0, 0, 0);
      step(4'b1000, 0, 0, 0, 0);
`ifdef CHAR_AIR_JUMP_EN
      chk("rearmed_state", 32'(state), S_JUMP);
`else
      chk("rearmed_state", 32'(state), S_FALL);
`endif

      // Random play.
      reset_dut();
      for (int i = 0; i < 500; i++) begin
         step(4'($urandom),
              ($urandom_range(3) == 0), ($urandom_range(3) == 0),
              ($urandom_range(7) == 0), ($urandom_range(1) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
